// File: rtl/hamming_serial_decoder_pkg.sv
// Shared types and constant helpers for the serial Hamming decoder.
// Build option: HAMMING_SECDED_EN adds an overall parity bit (SECDED).
package hamming_pkg;

  typedef logic [1:0] state_t;

  localparam state_t COLLECT = 2'd0;
  localparam state_t CORRECT = 2'd1;
  localparam state_t OUTPUT  = 2'd2;

  function automatic int calc_n(input int m);
    return (1 << m) - 1;
  endfunction

  function automatic int calc_k(input int m);
    return (1 << m) - 1 - m;
  endfunction

  function automatic logic is_pow2(input int v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  // 1-based code position of data bit idx (0-based)
  function automatic int data_pos(input int idx);
    int r;
    int c;
    r = 0;
    c = 0;
    for (int p = 1; p < 128; p++) begin
      if (!is_pow2(p)) begin
        if (c == idx && r == 0) r = p;
        c++;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/hamming_serial_decoder_if.sv
// Serial-in / parallel-out handshake bundle of the Hamming decoder.
// Build option: HAMMING_SECDED_EN (no effect on the signal set).
interface hamming_serial_decoder_if
  import hamming_pkg::*;
#(
  parameter int M     = 3,
  parameter int CNT_W = 16
);
  localparam int K = calc_k(M);

  logic             in_bit;
  logic             in_valid;
  logic             in_ready;
  logic [K-1:0]     out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_err;
  logic [M-1:0]     out_err_pos;
  logic             out_err_dbl;
  logic [CNT_W-1:0] err_count;

  modport master (
    output in_bit, in_valid, out_ready,
    input  in_ready, out_data, out_valid,
    input  out_err, out_err_pos, out_err_dbl,
    input  err_count
  );

  modport slave (
    input  in_bit, in_valid, out_ready,
    output in_ready, out_data, out_valid,
    output out_err, out_err_pos, out_err_dbl,
    output err_count
  );

endinterface

// File: rtl/hamming_serial_decoder_data_extract.sv
// Pulls the K data bits out of a corrected Hamming codeword.
// Build option: HAMMING_SECDED_EN (no effect here).
module hamming_data_extract
  import hamming_pkg::*;
#(
  parameter int M = 3
) (
  input  logic [calc_n(M)-1:0] code,
  output logic [calc_k(M)-1:0] data
);
  localparam int K = calc_k(M);

  always_comb begin
    data = '0;
    for (int i = 0; i < K; i++)
      data[i] = code[data_pos(i) - 1];
  end

endmodule

// File: rtl/hamming_serial_decoder.sv
// Serial-in Hamming(2^M-1) decoder with on-the-fly syndrome.
// Build option: HAMMING_SECDED_EN appends an overall parity bit.
module hamming_serial_decoder
  import hamming_pkg::*;
#(
  parameter int M     = 3,
  parameter int CNT_W = 16
) (
  input logic clk_in,
  input logic rst_n,
  hamming_serial_decoder_if.slave bus
);
  localparam int N  = calc_n(M);
  localparam int K  = calc_k(M);
  localparam int PW = M + 1;
`ifdef HAMMING_SECDED_EN
  localparam int W = N + 1;
`else
  localparam int W = N;
`endif
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           st;
  logic [PW-1:0]    pos;
  logic [M-1:0]     syn;
  logic [N-1:0]     code;
  logic [N-1:0]     fix;
  logic [N-1:0]     corr;
  logic [K-1:0]     data;
  logic [K-1:0]     data_q;
  logic             err;
  logic             dbl;
  logic             do_fix;
  logic             err_q;
  logic             dbl_q;
  logic [M-1:0]     err_pos;
  logic [M-1:0]     err_pos_q;
  logic [CNT_W-1:0] cnt;
  logic             acc;
  logic             last;
  logic             done;

  assign acc  = (st == COLLECT) && bus.in_valid;
  assign last = pos == PW'(W);
  assign done = (st == OUTPUT) && bus.out_ready;

`ifdef HAMMING_SECDED_EN
  logic par;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      par <= 1'b0;
    end else if (acc) begin
      par <= par ^ bus.in_bit;
    end else if (done) begin
      par <= 1'b0;
    end
  end

  // odd overall parity means an odd number of flips
  assign do_fix = (syn != '0) && par;
  assign err    = par;
  assign dbl    = (syn != '0) && !par;
`else
  assign do_fix = syn != '0;
  assign err    = do_fix;
  assign dbl    = 1'b0;
`endif

  assign err_pos = err ? syn : '0;

  always_comb begin
    fix = '0;
    for (int i = 0; i < N; i++)
      fix[i] = do_fix && (syn == M'(i + 1));
  end

  assign corr = code ^ fix;

  hamming_data_extract #(
    .M(M)
  ) u_ext (
    .code(corr),
    .data(data)
  );

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      st        <= COLLECT;
      pos       <= PW'(1);
      syn       <= '0;
      code      <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      err_pos_q <= '0;
      dbl_q     <= 1'b0;
      cnt       <= '0;
    end else begin
      unique case (1'b1)
        st == COLLECT: begin
          if (acc) begin
            if (bus.in_bit && pos <= PW'(N))
              syn <= syn ^ pos[M-1:0];
            for (int i = 0; i < N; i++)
              if (pos == PW'(i + 1)) code[i] <= bus.in_bit;
            if (last) st <= CORRECT;
            else pos <= pos + 1'b1;
          end
        end
        st == CORRECT: begin
          data_q    <= data;
          err_q     <= err;
          err_pos_q <= err_pos;
          dbl_q     <= dbl;
          if (err && cnt != CNT_MAX) cnt <= cnt + 1'b1;
          st <= OUTPUT;
        end
        st == OUTPUT: begin
          if (bus.out_ready) begin
            st  <= COLLECT;
            pos <= PW'(1);
            syn <= '0;
          end
        end
        default: st <= COLLECT;
      endcase
    end
  end

  assign bus.in_ready    = st == COLLECT;
  assign bus.out_valid   = st == OUTPUT;
  assign bus.out_data    = data_q;
  assign bus.out_err     = err_q;
  assign bus.out_err_pos = err_pos_q;
  assign bus.out_err_dbl = dbl_q;
  assign bus.err_count   = cnt;

endmodule

// File: tb/tb_hamming_serial_decoder.sv
// Directed bench for the serial Hamming decoder (M=3, 2-bit counter).
// Build option: HAMMING_SECDED_EN adds an M=4 SECDED instance.
module tb_hamming_serial_decoder;
  localparam int M  = 3;
  localparam int N  = 7;
  localparam int K  = 4;
  localparam int CW = 2;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  int   errs   = 0;
  int   checks = 0;

  always #5 clk_in = ~clk_in;

  hamming_serial_decoder_if #(.M(M), .CNT_W(CW)) bus ();

  hamming_serial_decoder #(
    .M(M),
    .CNT_W(CW)
  ) u_dut (
    .clk_in(clk_in),
    .rst_n(rst_n),
    .bus(bus)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    int n;
    n = 0;
    bus.in_bit   = b;
    bus.in_valid = 1'b1;
    forever begin
      @(negedge clk_in);
      if (bus.in_ready) break;
      n++;
      if (n > 50) begin
        errs++;
        $display("FAIL accept_timeout: in_ready stuck at 0");
        break;
      end
    end
    @(posedge clk_in);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [N-1:0] cw, input logic pb);
    for (int i = 0; i < N; i++) send_bit(cw[i]);
`ifdef HAMMING_SECDED_EN
    send_bit(pb);
`else
    if (pb === 1'bx) $display("parity bit unknown");
`endif
  endtask

  task automatic get_word(
    output logic [K-1:0] d,
    output logic         e,
    output logic [M-1:0] p
  );
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk_in);
      if (bus.out_valid) break;
      n++;
      if (n > 50) begin
        errs++;
        $display("FAIL valid_timeout: out_valid stuck at 0");
        break;
      end
    end
    d = bus.out_data;
    e = bus.out_err;
    p = bus.out_err_pos;
    @(posedge clk_in);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 1);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_out_data"}, 32'(bus.out_data), 0);
    check({tag, "_out_err"}, 32'(bus.out_err), 0);
    check({tag, "_err_pos"}, 32'(bus.out_err_pos), 0);
    check({tag, "_err_dbl"}, 32'(bus.out_err_dbl), 0);
    check({tag, "_err_count"}, 32'(bus.err_count), 0);
  endtask

`ifdef HAMMING_SECDED_EN
  hamming_serial_decoder_if #(.M(4), .CNT_W(16)) bus4 ();

  hamming_serial_decoder #(
    .M(4),
    .CNT_W(16)
  ) u_dut4 (
    .clk_in(clk_in),
    .rst_n(rst_n),
    .bus(bus4)
  );

  initial begin
    bus4.in_bit    = 1'b0;
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b0;
  end

  task automatic send4(input logic [15:0] w);
    for (int i = 0; i < 16; i++) begin
      bus4.in_bit   = w[i];
      bus4.in_valid = 1'b1;
      @(posedge clk_in);
      #1;
    end
    bus4.in_valid = 1'b0;
    @(posedge clk_in);
    #1;
  endtask

  task automatic ack4();
    bus4.out_ready = 1'b1;
    @(posedge clk_in);
    #1;
    bus4.out_ready = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [K-1:0] d;
    logic         e;
    logic [M-1:0] p;

    bus.in_bit    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    check_reset_vals("rst");
    @(negedge clk_in);
    rst_n = 1'b1;
    @(posedge clk_in);
    #1;

    // clean word 1,1,1,0,0,0,0 -> data 0001, valid two edges after last bit
    send_word(7'b0000111, 1'b1);
    check("clean_correct_valid", 32'(bus.out_valid), 0);
    check("clean_correct_ready", 32'(bus.in_ready), 0);
    @(posedge clk_in);
    #1;
    check("clean_valid", 32'(bus.out_valid), 1);
    get_word(d, e, p);
    check("clean_data", 32'(d), 4'b0001);
    check("clean_err", 32'(e), 0);
    check("clean_pos", 32'(p), 0);
    check("clean_ready_after", 32'(bus.in_ready), 1);
    check("clean_valid_after", 32'(bus.out_valid), 0);

    // zero word, position 5 flipped
    send_word(7'b0010000, 1'b0);
    get_word(d, e, p);
    check("single_data", 32'(d), 0);
    check("single_err", 32'(e), 1);
    check("single_pos", 32'(p), 5);
    check("single_count", 32'(bus.err_count), 1);

    // backpressure: word 1010 held, bits offered meanwhile
    send_word(7'b1010010, 1'b1);
    @(posedge clk_in);
    #1;
    bus.in_bit   = 1'b1;
    bus.in_valid = 1'b1;
    repeat (10) @(posedge clk_in);
    #1;
    check("bp_in_ready", 32'(bus.in_ready), 0);
    check("bp_out_valid", 32'(bus.out_valid), 1);
    check("bp_out_data", 32'(bus.out_data), 4'b1010);
    check("bp_out_err", 32'(bus.out_err), 0);
    bus.in_valid = 1'b0;
    get_word(d, e, p);
    check("bp_data", 32'(d), 4'b1010);
    send_word(7'b1010110, 1'b1);
    get_word(d, e, p);
    check("bp_next_data", 32'(d), 4'b1010);
    check("bp_next_err", 32'(e), 1);
    check("bp_next_pos", 32'(p), 3);
    check("bp_next_count", 32'(bus.err_count), 2);

    // reset after four bits of a word
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk_in);
    rst_n = 1'b1;
    @(posedge clk_in);
    #1;
    send_word(7'b1010010, 1'b1);
    get_word(d, e, p);
    check("midrst_data", 32'(d), 4'b1010);
    check("midrst_err", 32'(e), 0);

    // counter saturation at 3
    for (int i = 0; i < 5; i++) begin
      send_word(7'(1 << i), 1'b0);
      get_word(d, e, p);
      check("sat_data", 32'(d), 0);
      check("sat_pos", 32'(p), i + 1);
      check("sat_count", 32'(bus.err_count), (i < 3) ? i + 1 : 3);
    end

`ifdef HAMMING_SECDED_EN
    // positions 2 and 9 flipped: double error
    send4(16'h0102);
    check("dbl_valid", 32'(bus4.out_valid), 1);
    check("dbl_flag", 32'(bus4.out_err_dbl), 1);
    check("dbl_err", 32'(bus4.out_err), 0);
    check("dbl_data", 32'(bus4.out_data), 16'h0010);
    check("dbl_count", 32'(bus4.err_count), 0);
    ack4();
    // position 9 alone
    send4(16'h0100);
    check("sec_err", 32'(bus4.out_err), 1);
    check("sec_pos", 32'(bus4.out_err_pos), 9);
    check("sec_data", 32'(bus4.out_data), 0);
    check("sec_dbl", 32'(bus4.out_err_dbl), 0);
    check("sec_count", 32'(bus4.err_count), 1);
    ack4();
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
